mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4, max consecutive DMA-owned cycles before the CPU is forced one cycle (legal 1..7).
REQ-002 CLK  in  1  system clock, all state updates on rising edge.
REQ-003 R  in  1  reset, asynchronous, active-low.
REQ-004 cpu_addr  in  16 / cpu_wdata  in  8 / cpu_we  in  1: CPU access for the current cycle.
REQ-005 cpu_lock  in  1  CPU read-modify-write in progress; no new DMA grant while high.
REQ-006 cpu_rdy  out  1  CPU owns memory this cycle; CPU shall hold state when low.
REQ-007 cpu_rdata  out  8  memory read data to the CPU.
REQ-008 dma_req  in  1 / dma_addr  in  16 / dma_wdata  in  8 / dma_we  in  1: DMA access request.
REQ-009 dma_gnt  out  1  DMA access performed this cycle.
REQ-010 dma_rdata  out  8  memory read data to DMA, valid while dma_gnt high.
REQ-011 mem_addr  out  16 / mem_wdata  out  8 / mem_we  out  1: to MEMORY Address/DataIn/WE.
REQ-012 mem_rdata  in  8  from MEMORY DataOut (combinational read).
REQ-013 steal_cnt  out  16  saturating count of cycles with cpu_rdy low.

Function
REQ-014 States: ST_CPU, ST_DMA, ST_HOLD (2-bit register); burst_cnt 3-bit register.
REQ-015 dma_gnt = (state==ST_DMA) && dma_req; cpu_rdy = !dma_gnt; exactly one owner every cycle.
REQ-016 Owner mux combinational: mem_addr/mem_wdata from DMA when dma_gnt, else from CPU.
REQ-017 mem_we = dma_gnt ? (dma_we gated per REQ-030) : cpu_we.
REQ-018 cpu_rdata and dma_rdata both driven by mem_rdata; only the owner's copy is meaningful.
REQ-019 ST_CPU: dma_req && !cpu_lock -> ST_DMA, burst_cnt<=0; else stay.
REQ-020 ST_DMA with dma_req: burst_cnt<=burst_cnt+1; if burst_cnt==BURST_MAX-1 -> ST_HOLD, else stay.
REQ-021 ST_DMA with !dma_req: -> ST_CPU, no DMA access, CPU owns that cycle (no idle cycle).
REQ-022 ST_HOLD: CPU owns; next -> ST_DMA (burst_cnt<=0) if dma_req && !cpu_lock, else ST_CPU.
REQ-023 cpu_lock has no effect once in ST_DMA; an active burst completes per REQ-020/021.
REQ-024 Grant latency: dma_req asserted in cycle N from ST_CPU -> first dma_gnt in cycle N+1.
REQ-025 steal_cnt increments each cycle dma_gnt is high; holds at 16'hFFFF (no wrap).
REQ-026 Illegal state encoding -> ST_CPU next cycle.

Reset
REQ-027 R low: immediately state=ST_CPU, burst_cnt=0, steal_cnt=0; thus dma_gnt=0, cpu_rdy=1, mem_we=cpu_we.
REQ-028 Reset asserted mid-burst aborts the burst asynchronously; no DMA write occurs while R low.
REQ-029 First transition possible on first rising CLK after R deasserts.

Configuration
REQ-030 Macro DMA_WRITE_EN: defined -> DMA writes allowed (mem_we=dma_we during dma_gnt); undefined -> DMA read-only, mem_we=0 during dma_gnt, dma_we and dma_wdata ignored.

Verification
REQ-031 Reset, no requests, cpu_addr=16'h0200, cpu_we=1 -> mem_addr=16'h0200, mem_we=1, cpu_rdy=1, steal_cnt=0.
REQ-032 dma_req held 10 cycles, BURST_MAX=4 -> dma_gnt pattern 0,1,1,1,1,0,1,1,1,1 (first 0 = grant latency); steal_cnt=8.
REQ-033 cpu_lock=1 with dma_req=1 for 3 cycles, then cpu_lock=0 -> dma_gnt stays 0 until cycle after lock drops.
REQ-034 DMA write 8'hA5 to 16'h1000 granted -> with DMA_WRITE_EN mem_we=1, mem_wdata=8'hA5; without, mem_we=0.
REQ-035 R low during 2nd burst cycle -> dma_gnt=0, cpu_rdy=1 same cycle; steal_cnt=0.
REQ-036 Force steal_cnt=16'hFFFE, grant 3 DMA cycles -> steal_cnt ends 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// CPU/DMA single-port memory arbiter with bounded DMA bursts and a cycle-steal counter.
// Optional feature: define DMA_WRITE_EN to let DMA write; otherwise DMA is read-only.
module mem_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_lock,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] steal_cnt
);

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_DMA  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] BURST_LAST = 3'(BURST_MAX - 1);

    state_t      state_q, state_d;
    logic [2:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0] steal_cnt_q, steal_cnt_d;
    logic        dma_we_eff;

`ifdef DMA_WRITE_EN
    assign dma_we_eff = dma_we;
`else
    logic dma_we_unused;
    assign dma_we_unused = dma_we;
    assign dma_we_eff    = 1'b0;
`endif

    assign dma_gnt   = (state_q == ST_DMA) && dma_req;
    assign cpu_rdy   = !dma_gnt;
    assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
    assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    assign mem_we    = dma_gnt ? dma_we_eff : cpu_we;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign steal_cnt = steal_cnt_q;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        steal_cnt_d = steal_cnt_q;
        case (state_q)
            ST_CPU, ST_HOLD: begin
                // HOLD gives the CPU exactly one cycle, then arbitrates like CPU
                if (dma_req && !cpu_lock) begin
                    state_d     = ST_DMA;
                    burst_cnt_d = 3'd0;
                end else begin
                    state_d = ST_CPU;
                end
            end
            ST_DMA: begin
                if (dma_req) begin
                    burst_cnt_d = burst_cnt_q + 3'd1;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_CPU;
                end
            end
            default: state_d = ST_CPU;
        endcase
        if (dma_gnt && (steal_cnt_q != 16'hFFFF)) begin
            steal_cnt_d = steal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q     <= ST_CPU;
            burst_cnt_q <= 3'd0;
            steal_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            steal_cnt_q <= steal_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mem_arbiter;
    localparam int BM = 4;

    logic        CLK = 1'b0;
    logic        R;
    logic [15:0] cpu_addr, dma_addr, mem_addr, steal_cnt;
    logic [7:0]  cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
    logic        cpu_we, cpu_lock, cpu_rdy, dma_req, dma_we, dma_gnt, mem_we;

    int vec_cnt = 0;
    int err_cnt = 0;

    // model: is a DMA burst running, how many grants in it so far, stolen cycles
    bit          m_dma;
    int          m_run;
    int unsigned m_steal;

    mem_arbiter #(.BURST_MAX(BM)) dut (
        .CLK(CLK), .R(R),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .steal_cnt(steal_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic bit m_gnt();
        return m_dma && dma_req;
    endfunction

    function automatic bit exp_we(bit g);
`ifdef DMA_WRITE_EN
        return g ? dma_we : cpu_we;
`else
        return g ? 1'b0 : cpu_we;
`endif
    endfunction

    task automatic model_reset();
        m_dma = 0; m_run = 0; m_steal = 0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic tick();
        @(posedge CLK);
        if (m_gnt()) m_steal = (m_steal >= 32'hFFFF) ? 32'hFFFF : m_steal + 1;
        if (m_dma) begin
            if (dma_req) begin
                m_run++;
                if (m_run >= BM) m_dma = 0;   // CPU gets one forced cycle
            end else begin
                m_dma = 0;
            end
        end else begin
            m_dma = dma_req && !cpu_lock;
            m_run = 0;
        end
    endtask

    task automatic idle_inputs();
        dma_req = 0; cpu_lock = 0; cpu_we = 0; dma_we = 0;
        cpu_addr = 16'h0000; dma_addr = 16'h0000; cpu_wdata = 8'h00; dma_wdata = 8'h00;
        mem_rdata = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        R = 0;
        model_reset();
        @(negedge CLK);
        R = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        R = 0;
        cpu_addr = 16'h0200; cpu_we = 1; cpu_wdata = 8'h3C;
        model_reset();
        #2;
        vec_cnt++; if (mem_addr !== 16'h0200) begin err_cnt++; $display("FAIL reset_addr got %h exp 0200", mem_addr); end
        vec_cnt++; if (mem_we !== 1'b1) begin err_cnt++; $display("FAIL reset_we got %b exp 1", mem_we); end
        vec_cnt++; if (cpu_rdy !== 1'b1) begin err_cnt++; $display("FAIL reset_rdy got %b exp 1", cpu_rdy); end
        vec_cnt++; if (steal_cnt !== 16'h0000) begin err_cnt++; $display("FAIL reset_steal got %h exp 0000", steal_cnt); end
        vec_cnt++; if (dma_gnt !== 1'b0) begin err_cnt++; $display("FAIL reset_gnt got %b exp 0", dma_gnt); end
        @(negedge CLK);
        R = 1;
        tick();
        @(negedge CLK); #1;
        vec_cnt++; if (cpu_rdy !== 1'b1 || mem_addr !== 16'h0200) begin
            err_cnt++; $display("FAIL idle_cpu rdy %b addr %h exp 1 0200", cpu_rdy, mem_addr);
        end
        tick();
    endtask

    task automatic test_burst();
        logic [9:0] pat;
        pat = 10'b1111011110;   // bit i = expected grant in cycle i
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            dma_req = 1; dma_addr = 16'h4000 + 16'(i); cpu_addr = 16'h0100;
            #1;
            vec_cnt++; if (dma_gnt !== pat[i] || cpu_rdy !== !pat[i]) begin
                err_cnt++; $display("FAIL burst_gnt cyc %0d got gnt %b rdy %b exp gnt %b", i, dma_gnt, cpu_rdy, pat[i]);
            end
            tick();
        end
        @(negedge CLK); #1;
        vec_cnt++; if (steal_cnt !== 16'd8) begin err_cnt++; $display("FAIL burst_steal got %0d exp 8", steal_cnt); end
        dma_req = 0;
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            dma_req = 1; cpu_lock = (i < 3);
            #1;
            vec_cnt++; if (dma_gnt !== (i == 4)) begin
                err_cnt++; $display("FAIL lock_gnt cyc %0d got %b exp %b", i, dma_gnt, (i == 4));
            end
            tick();
        end
        @(negedge CLK);
        idle_inputs();
        tick();
    endtask

    task automatic test_dma_write();
        do_reset();
        @(negedge CLK);
        dma_req = 1; dma_we = 1; dma_addr = 16'h1000; dma_wdata = 8'hA5;
        cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h11;
        #1;
        vec_cnt++; if (dma_gnt !== 1'b0 || mem_addr !== 16'h0200 || mem_we !== 1'b1) begin
            err_cnt++; $display("FAIL wr_latency gnt %b addr %h we %b exp 0 0200 1", dma_gnt, mem_addr, mem_we);
        end
        tick();
        @(negedge CLK); #1;
`ifdef DMA_WRITE_EN
        vec_cnt++; if (dma_gnt !== 1'b1 || mem_addr !== 16'h1000 || mem_we !== 1'b1 || mem_wdata !== 8'hA5) begin
            err_cnt++; $display("FAIL wr_grant gnt %b addr %h we %b wd %h exp 1 1000 1 a5", dma_gnt, mem_addr, mem_we, mem_wdata);
        end
`else
        vec_cnt++; if (dma_gnt !== 1'b1 || mem_addr !== 16'h1000 || mem_we !== 1'b0) begin
            err_cnt++; $display("FAIL wr_grant_ro gnt %b addr %h we %b exp 1 1000 0", dma_gnt, mem_addr, mem_we);
        end
`endif
        tick();
        @(negedge CLK);
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        @(negedge CLK);
        dma_req = 1; dma_we = 1; cpu_we = 0;
        tick();
        @(negedge CLK);
        tick();
        @(negedge CLK); #1;
        vec_cnt++; if (dma_gnt !== 1'b1) begin err_cnt++; $display("FAIL mid_pre gnt got %b exp 1", dma_gnt); end
        R = 0;
        model_reset();
        #1;
        vec_cnt++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin
            err_cnt++; $display("FAIL mid_abort gnt %b rdy %b exp 0 1", dma_gnt, cpu_rdy);
        end
        vec_cnt++; if (steal_cnt !== 16'h0000) begin err_cnt++; $display("FAIL mid_steal got %h exp 0000", steal_cnt); end
        @(posedge CLK); #1;
        vec_cnt++; if (mem_we !== 1'b0 || dma_gnt !== 1'b0) begin
            err_cnt++; $display("FAIL mid_hold we %b gnt %b exp 0 0", mem_we, dma_gnt);
        end
        @(negedge CLK);
        idle_inputs();
        R = 1;
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge CLK);
        force dut.steal_cnt_q = 16'hFFFE;
        #1;
        release dut.steal_cnt_q;
        m_steal = 32'hFFFE;
        dma_req = 1;
        #1;
        vec_cnt++; if (steal_cnt !== 16'hFFFE) begin err_cnt++; $display("FAIL sat_preset got %h exp fffe", steal_cnt); end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); #1;
            vec_cnt++; if (steal_cnt !== 16'(m_steal) || dma_gnt !== m_gnt()) begin
                err_cnt++; $display("FAIL sat_step %0d steal %h gnt %b exp %h %b", i, steal_cnt, dma_gnt, 16'(m_steal), m_gnt());
            end
            if (i == 2) dma_req = 0;
            tick();
        end
        @(negedge CLK); #1;
        vec_cnt++; if (steal_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL sat_final got %h exp ffff", steal_cnt); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            dma_req   = ($urandom_range(0, 3) != 0);
            cpu_lock  = ($urandom_range(0, 4) == 0);
            cpu_we    = 1'($urandom);
            dma_we    = 1'($urandom);
            cpu_addr  = 16'($urandom);
            dma_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            dma_wdata = 8'($urandom);
            mem_rdata = 8'($urandom);
            #1;
            g = m_gnt();
            vec_cnt++; if (dma_gnt !== g || cpu_rdy !== !g) begin
                err_cnt++; $display("FAIL rnd_owner cyc %0d gnt %b rdy %b exp gnt %b", i, dma_gnt, cpu_rdy, g);
            end
            vec_cnt++; if (mem_addr !== (g ? dma_addr : cpu_addr) || mem_wdata !== (g ? dma_wdata : cpu_wdata)) begin
                err_cnt++; $display("FAIL rnd_mux cyc %0d addr %h wd %h exp %h %h", i, mem_addr, mem_wdata,
                                    g ? dma_addr : cpu_addr, g ? dma_wdata : cpu_wdata);
            end
            vec_cnt++; if (mem_we !== exp_we(g)) begin
                err_cnt++; $display("FAIL rnd_we cyc %0d got %b exp %b", i, mem_we, exp_we(g));
            end
            vec_cnt++; if (steal_cnt !== 16'(m_steal)) begin
                err_cnt++; $display("FAIL rnd_steal cyc %0d got %0d exp %0d", i, steal_cnt, m_steal);
            end
            vec_cnt++; if (cpu_rdata !== mem_rdata || dma_rdata !== mem_rdata) begin
                err_cnt++; $display("FAIL rnd_rdata cyc %0d cpu %h dma %h exp %h", i, cpu_rdata, dma_rdata, mem_rdata);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_lock();
        test_dma_write();
        test_reset_mid_burst();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
